// File: rtl/ld_pkg.sv
// Shared types and PC slicing helpers for the loop-trip-count predictor.
// Entry fields are sized to fixed maxima so one struct serves every parameterisation.
package ld_pkg;

    localparam int LD_TAG_MAX    = 16;
    localparam int LD_CNT_MAX    = 16;
    localparam int LD_CONF_MAX   = 4;
    localparam int LD_INDEX_BITS = 6;
    localparam int DEPTH         = 2 ** LD_INDEX_BITS;

    typedef struct packed {
        logic                   valid;
        logic [LD_TAG_MAX-1:0]  tag;
        logic [LD_CNT_MAX-1:0]  trip;
        logic [LD_CNT_MAX-1:0]  iter;
        logic [LD_CONF_MAX-1:0] conf;
    } ld_entry_t;

    function automatic logic [63:0] ld_index(input logic [63:0] pc, input int index_bits);
        return (pc >> 2) & ((64'd1 << index_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] ld_tag(input logic [63:0] pc, input int index_bits,
                                           input int tag_bits);
        return (pc >> (index_bits + 2)) & ((64'd1 << tag_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/ld_table.sv
// Flop-array entry store: lookup and update read ports, one write port.
// Only the valid bits are cleared; the other fields are rewritten on allocation.
module ld_table
    import ld_pkg::*;
#(
    parameter int INDEX_BITS = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [INDEX_BITS-1:0] lu_idx,
    output ld_entry_t             lu_entry,
    input  logic [INDEX_BITS-1:0] up_idx,
    output ld_entry_t             up_entry,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  ld_entry_t             wr_entry
);

    localparam int N = 2 ** INDEX_BITS;

    ld_entry_t entries [N];

    assign lu_entry = entries[lu_idx];
    assign up_entry = entries[up_idx];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < N; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            entries[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/loop_detector_param.sv
// Tagged loop-trip-count predictor: learns backward-branch trip counts at execute
// and overrides the fetch-time direction once the count has been confirmed.
module loop_detector_param
    import ld_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int INDEX_BITS  = 6,
    parameter int TAG_BITS    = 8,
    parameter int CNT_BITS    = 10,
    parameter int CONF_BITS   = 2,
    parameter int CONF_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC_F,
    input  logic             branch_en_F,
    input  logic [WIDTH-1:0] PC_EX,
    input  logic [WIDTH-1:0] PC_destination,
    input  logic             branch_en_EX,
    input  logic             feedback_from_ALU,
    input  logic             ld_clear,
    output logic             loop_decision,
    output logic             LD_en
);

    localparam logic [LD_CNT_MAX-1:0]  CNT_MASK  = LD_CNT_MAX'((64'd1 << CNT_BITS) - 64'd1);
    localparam logic [LD_CONF_MAX-1:0] CONF_MASK = LD_CONF_MAX'((64'd1 << CONF_BITS) - 64'd1);
    localparam logic [LD_CONF_MAX-1:0] CONF_MIN  = LD_CONF_MAX'(CONF_THRESH);

    logic [INDEX_BITS-1:0] f_idx;
    logic [INDEX_BITS-1:0] x_idx;
    logic [LD_TAG_MAX-1:0] f_tag;
    logic [LD_TAG_MAX-1:0] x_tag;
    ld_entry_t             lu_entry;
    ld_entry_t             up_entry;
    ld_entry_t             wr_entry;
    logic                  wr_en;
    logic                  f_hit;
    logic                  f_dec;
    logic                  x_match;
    logic                  backward;
    logic [LD_CNT_MAX-1:0] x_total;

    assign f_idx = INDEX_BITS'(ld_index(64'(PC_F), INDEX_BITS));
    assign x_idx = INDEX_BITS'(ld_index(64'(PC_EX), INDEX_BITS));
    assign f_tag = LD_TAG_MAX'(ld_tag(64'(PC_F), INDEX_BITS, TAG_BITS));
    assign x_tag = LD_TAG_MAX'(ld_tag(64'(PC_EX), INDEX_BITS, TAG_BITS));

    ld_table #(
        .INDEX_BITS(INDEX_BITS)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .clear    (ld_clear),
        .lu_idx   (f_idx),
        .lu_entry (lu_entry),
        .up_idx   (x_idx),
        .up_entry (up_entry),
        .wr_en    (wr_en),
        .wr_idx   (x_idx),
        .wr_entry (wr_entry)
    );

    assign f_hit    = lu_entry.valid && (lu_entry.tag == f_tag) && (lu_entry.conf >= CONF_MIN);
    assign f_dec    = ((lu_entry.iter + 1'b1) & CNT_MASK) != lu_entry.trip;
    assign x_match  = up_entry.valid && (up_entry.tag == x_tag);
    assign backward = PC_destination < PC_EX;
    assign x_total  = (up_entry.iter + 1'b1) & CNT_MASK;

    // Confidence is deliberately ignored here so an unconfirmed entry keeps training.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = up_entry;
        if (branch_en_EX) begin
            if (x_match) begin
                wr_en = 1'b1;
                if (feedback_from_ALU) begin
                    if (up_entry.iter == CNT_MASK) begin
                        wr_entry.valid = 1'b0;
                    end else begin
                        wr_entry.iter = up_entry.iter + 1'b1;
                    end
                end else begin
                    if (x_total == up_entry.trip) begin
                        if (up_entry.conf != CONF_MASK) begin
                            wr_entry.conf = up_entry.conf + 1'b1;
                        end
                    end else begin
                        wr_entry.trip = x_total;
                        wr_entry.conf = '0;
                    end
                    wr_entry.iter = '0;
                end
            end else if (feedback_from_ALU && backward) begin
                wr_en          = 1'b1;
                wr_entry.valid = 1'b1;
                wr_entry.tag   = x_tag;
                wr_entry.iter  = LD_CNT_MAX'(1);
                wr_entry.trip  = '0;
                wr_entry.conf  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ld_clear) begin
            LD_en         <= 1'b0;
            loop_decision <= 1'b0;
        end else if (branch_en_F) begin
            LD_en         <= f_hit;
            loop_decision <= f_hit && f_dec;
        end else begin
            LD_en         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_loop_detector_param.sv
// Self-checking bench for loop_detector_param: directed loop scenarios followed by
// randomized loop traffic, all checked against an array-based behavioural model.
module tb_loop_detector_param;

    localparam int WIDTH       = 32;
    localparam int INDEX_BITS  = 6;
    localparam int TAG_BITS    = 8;
    localparam int CNT_BITS    = 4;
    localparam int CONF_BITS   = 2;
    localparam int CONF_THRESH = 3;
    localparam int NENT        = 1 << INDEX_BITS;
    localparam int CNT_MOD     = 1 << CNT_BITS;
    localparam int CONF_TOP    = (1 << CONF_BITS) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] PC_F;
    logic             branch_en_F;
    logic [WIDTH-1:0] PC_EX;
    logic [WIDTH-1:0] PC_destination;
    logic             branch_en_EX;
    logic             feedback_from_ALU;
    logic             ld_clear;
    logic             loop_decision;
    logic             LD_en;

    int total = 0;
    int bad   = 0;

    bit mValid [NENT];
    int mTag   [NENT];
    int mTrip  [NENT];
    int mIter  [NENT];
    int mConf  [NENT];
    bit expEn  = 1'b0;
    bit expDec = 1'b0;

    always #5 clk = ~clk;

    loop_detector_param #(
        .WIDTH(WIDTH), .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS),
        .CNT_BITS(CNT_BITS), .CONF_BITS(CONF_BITS), .CONF_THRESH(CONF_THRESH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .PC_F              (PC_F),
        .branch_en_F       (branch_en_F),
        .PC_EX             (PC_EX),
        .PC_destination    (PC_destination),
        .branch_en_EX      (branch_en_EX),
        .feedback_from_ALU (feedback_from_ALU),
        .ld_clear          (ld_clear),
        .loop_decision     (loop_decision),
        .LD_en             (LD_en)
    );

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic int tagOf(input logic [31:0] pc);
        return int'((pc >> (INDEX_BITS + 2)) % (1 << TAG_BITS));
    endfunction

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive, let the model take the same edge, then compare outputs.
    task automatic applyStimulus(input bit fe, input logic [31:0] pcf, input bit ex,
                                 input logic [31:0] pcex, input logic [31:0] dst,
                                 input bit tk, input bit clr, input bit rs);
        int  i;
        int  j;
        int  tot;
        bit  hit;
        branch_en_F       = fe;
        PC_F              = pcf;
        branch_en_EX      = ex;
        PC_EX             = pcex;
        PC_destination    = dst;
        feedback_from_ALU = tk;
        ld_clear          = clr;
        rst               = rs;
        @(posedge clk);
        if (rs || clr) begin
            foreach (mValid[k]) mValid[k] = 1'b0;
            expEn  = 1'b0;
            expDec = 1'b0;
        end else begin
            if (fe) begin
                i      = idxOf(pcf);
                hit    = mValid[i] && (mTag[i] == tagOf(pcf)) && (mConf[i] >= CONF_THRESH);
                expEn  = hit;
                expDec = hit && (((mIter[i] + 1) % CNT_MOD) != mTrip[i]);
            end else begin
                expEn = 1'b0;
            end
            if (ex) begin
                j = idxOf(pcex);
                if (mValid[j] && mTag[j] == tagOf(pcex)) begin
                    if (tk) begin
                        if (mIter[j] == CNT_MOD - 1) mValid[j] = 1'b0;
                        else mIter[j] = mIter[j] + 1;
                    end else begin
                        tot = (mIter[j] + 1) % CNT_MOD;
                        if (tot == mTrip[j]) begin
                            mConf[j] = (mConf[j] == CONF_TOP) ? CONF_TOP : mConf[j] + 1;
                        end else begin
                            mTrip[j] = tot;
                            mConf[j] = 0;
                        end
                        mIter[j] = 0;
                    end
                end else if (tk && dst < pcex) begin
                    mValid[j] = 1'b1;
                    mTag[j]   = tagOf(pcex);
                    mIter[j]  = 1;
                    mTrip[j]  = 0;
                    mConf[j]  = 0;
                end
            end
        end
        #1;
        checkOutput("LD_en", LD_en, expEn);
        checkOutput("loop_decision", loop_decision, expDec);
    endtask

    task automatic exStep(input logic [31:0] pc, input logic [31:0] dst, input bit tk);
        applyStimulus(1'b0, 32'h0, 1'b1, pc, dst, tk, 1'b0, 1'b0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        applyStimulus(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic trainInstance(input logic [31:0] pc, input logic [31:0] dst, input int len);
        for (int k = 0; k < len; k++) exStep(pc, dst, k < len - 1);
    endtask

    initial begin
        int e0;
        logic [31:0] pc;
        logic [31:0] dst;
        logic [31:0] pcf;
        int trip;
        int reps;
        int len;
        bit fe;

        e0 = idxOf(32'h100);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        lookup(32'h100);
        checkOutput("reset_en", LD_en, 0);

        trainInstance(32'h100, 32'h0F0, 4);
        checkOutput("trip_inst1", dut.u_table.entries[e0].trip, 4);
        checkOutput("conf_inst1", dut.u_table.entries[e0].conf, 0);
        for (int k = 0; k < 3; k++) trainInstance(32'h100, 32'h0F0, 4);
        checkOutput("conf_inst4", dut.u_table.entries[e0].conf, 3);

        // Lookup and update of the same entry share each cycle: decisions see pre-update iter.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 32'h0F0, k < 3, 1'b0, 1'b0);
            checkOutput("trained_en", LD_en, 1);
            checkOutput("trained_dec", loop_decision, k < 3);
        end

        trainInstance(32'h100, 32'h0F0, 6);
        checkOutput("trip_change", dut.u_table.entries[e0].trip, 6);
        checkOutput("conf_change", dut.u_table.entries[e0].conf, 0);
        lookup(32'h100);
        checkOutput("trip_change_en", LD_en, 0);
        for (int k = 0; k < 3; k++) trainInstance(32'h100, 32'h0F0, 6);
        lookup(32'h100);
        checkOutput("retrain_en", LD_en, 1);

        exStep(32'h200, 32'h240, 1'b1);
        lookup(32'h200);
        checkOutput("forward_en", LD_en, 0);

        exStep(32'h100 + (NENT << 2), 32'h0F0, 1'b1);
        checkOutput("alias_conf", dut.u_table.entries[e0].conf, 0);
        lookup(32'h100);
        checkOutput("alias_en", LD_en, 0);

        for (int k = 0; k < 4; k++) trainInstance(32'h100, 32'h0F0, 4);
        lookup(32'h100);
        checkOutput("pre_clear_en", LD_en, 1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 32'h0F0, 1'b1, 1'b1, 1'b0);
        lookup(32'h100);
        checkOutput("clear_en", LD_en, 0);

        for (int k = 0; k < CNT_MOD - 1; k++) exStep(32'h300, 32'h2F0, 1'b1);
        checkOutput("ovf_iter", dut.u_table.entries[idxOf(32'h300)].iter, CNT_MOD - 1);
        exStep(32'h300, 32'h2F0, 1'b1);
        checkOutput("ovf_valid", dut.u_table.entries[idxOf(32'h300)].valid, 0);

        for (int k = 0; k < 4; k++) trainInstance(32'h100, 32'h0F0, 4);
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 32'h0F0, 1'b1, 1'b0, 1'b1);
        lookup(32'h100);
        checkOutput("midrst_en", LD_en, 0);

        for (int r = 0; r < 200; r++) begin
            pc   = 32'($urandom_range(0, 15) * 32'h100 + $urandom_range(0, 3) * 4);
            dst  = ($urandom_range(0, 9) == 0) ? pc + 32'h40 : pc - 32'h10;
            trip = $urandom_range(1, 6);
            reps = $urandom_range(1, 5);
            for (int n = 0; n < reps; n++) begin
                len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 18) : trip;
                for (int it = 0; it < len; it++) begin
                    fe  = $urandom_range(0, 3) != 0;
                    pcf = ($urandom_range(0, 3) != 0) ? pc
                          : 32'($urandom_range(0, 15) * 32'h100 + $urandom_range(0, 3) * 4);
                    applyStimulus(fe, pcf, $urandom_range(0, 9) != 0, pc, dst, it < len - 1,
                                  $urandom_range(0, 299) == 0, $urandom_range(0, 399) == 0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
